// File: rtl/logic_unit_arbiter_pkg.sv
// Shared constants and types for the logic-unit arbiter slice.
package logic_unit_pkg;

   localparam logic OP_AND = 1'b0;
   localparam logic OP_OR  = 1'b1;

   // 2'd3 is unused; the FSM recovers it to ST_IDLE
   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_EXEC = 2'd1,
      ST_RESP = 2'd2
   } state_t;

   // requester-index width, never narrower than one bit
   function automatic int id_w(input int n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

endpackage

// File: rtl/logic_unit_arbiter_if.sv
// Bus bundle between requesters, the arbiter, the shared logic unit and the response consumer.
interface logic_unit_arbiter_if
   import logic_unit_pkg::*;
#(
   parameter int N_REQ = 2,
   parameter int WIDTH = 32
);
   localparam int ID_W = id_w(N_REQ);

   logic [N_REQ-1:0]       req_valid;
   logic [N_REQ-1:0]       req_ready;
   logic [N_REQ*WIDTH-1:0] req_a;
   logic [N_REQ*WIDTH-1:0] req_b;
   logic [N_REQ-1:0]       req_op;
   logic [WIDTH-1:0]       lu_a;
   logic [WIDTH-1:0]       lu_b;
   logic                   lu_ctrl;
   logic [WIDTH-1:0]       lu_y;
   logic                   resp_valid;
   logic                   resp_ready;
   logic [WIDTH-1:0]       resp_data;
   logic [ID_W-1:0]        resp_id;
   logic                   busy;

   // arbiter side
   modport slave (
      input  req_valid, req_a, req_b, req_op, lu_y, resp_ready,
      output req_ready, lu_a, lu_b, lu_ctrl, resp_valid, resp_data, resp_id, busy
   );

   // requester / unit / consumer side
   modport master (
      output req_valid, req_a, req_b, req_op, lu_y, resp_ready,
      input  req_ready, lu_a, lu_b, lu_ctrl, resp_valid, resp_data, resp_id, busy
   );

endinterface

// File: rtl/logic_unit_arbiter_rr_arbiter.sv
// Combinational round-robin picker: first set request at or after ptr, wrapping.
module rr_arbiter
   import logic_unit_pkg::*;
#(
   parameter int N_REQ = 2,
   parameter int ID_W  = id_w(N_REQ)
) (
   input  logic [N_REQ-1:0] req,
   input  logic [ID_W-1:0]  ptr,
   output logic [N_REQ-1:0] gnt,
   output logic [ID_W-1:0]  gnt_id,
   output logic             any
);

   // walk the requesters in priority order starting at ptr; first hit wins
   always_comb begin
      gnt    = '0;
      gnt_id = '0;
      any    = 1'b0;
      for (int k = 0; k < N_REQ; k++) begin
         if (!any && req[(int'(ptr) + k) % N_REQ]) begin
            any                          = 1'b1;
            gnt[(int'(ptr) + k) % N_REQ] = 1'b1;
            gnt_id                       = ID_W'((int'(ptr) + k) % N_REQ);
         end
      end
   end

endmodule

// File: rtl/logic_unit_arbiter.sv
// Shares one external AND/OR unit among N_REQ requesters: round-robin grant,
// operand capture, one EXEC cycle for the unit, then a held response.
module logic_unit_arbiter
   import logic_unit_pkg::*;
#(
   parameter int N_REQ = 2,
   parameter int WIDTH = 32
) (
   input logic                 clk,
   input logic                 rst_n,
   logic_unit_arbiter_if.slave bus
);

   localparam int ID_W = id_w(N_REQ);

   state_t            r_state;
   state_t            w_next;
   logic              w_accept;
   logic [ID_W-1:0]   r_rr_ptr;
   logic [ID_W-1:0]   w_rr_ptr_nxt;
   logic [N_REQ-1:0]  w_gnt;
   logic [ID_W-1:0]   w_gnt_id;
   logic              w_any;
   logic [WIDTH-1:0]  w_sel_a;
   logic [WIDTH-1:0]  w_sel_b;
   logic              w_sel_op;
   logic [WIDTH-1:0]  r_lu_a;
   logic [WIDTH-1:0]  r_lu_b;
   logic              r_lu_ctrl;
   logic              r_resp_valid;
   logic [WIDTH-1:0]  r_resp_data;
   logic [ID_W-1:0]   r_resp_id;

   rr_arbiter #(.N_REQ(N_REQ), .ID_W(ID_W)) u_rr (
      .req    (bus.req_valid),
      .ptr    (r_rr_ptr),
      .gnt    (w_gnt),
      .gnt_id (w_gnt_id),
      .any    (w_any)
   );

   assign w_sel_a  = bus.req_a[int'(w_gnt_id)*WIDTH +: WIDTH];
   assign w_sel_b  = bus.req_b[int'(w_gnt_id)*WIDTH +: WIDTH];
   assign w_sel_op = bus.req_op[w_gnt_id];

   // pointer moves just past the winner; with one requester it stays at 0
   assign w_rr_ptr_nxt = (w_gnt_id == ID_W'(N_REQ-1)) ? '0 : w_gnt_id + 1'b1;

   // state register
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) r_state <= ST_IDLE;
      else        r_state <= w_next;
   end

   // next-state and accept decode; unused encoding falls back to idle
   always_comb begin
      w_next   = r_state;
      w_accept = 1'b0;
      case (r_state)
         ST_IDLE: if (w_any) begin
            w_next   = ST_EXEC;
            w_accept = 1'b1;
         end
         ST_EXEC: w_next = ST_RESP;
         ST_RESP: if (bus.resp_ready) w_next = ST_IDLE;
         default: w_next = ST_IDLE;
      endcase
   end

   // capture the winner's operands and id; they hold until the next grant
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_lu_a    <= '0;
         r_lu_b    <= '0;
         r_lu_ctrl <= OP_AND;
         r_resp_id <= '0;
         r_rr_ptr  <= '0;
      end else if (w_accept) begin
         r_lu_a    <= w_sel_a;
         r_lu_b    <= w_sel_b;
         r_lu_ctrl <= w_sel_op;
         r_resp_id <= w_gnt_id;
         r_rr_ptr  <= w_rr_ptr_nxt;
      end
   end

   // sample the unit result in EXEC and hold it until the consumer takes it
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_resp_data  <= '0;
         r_resp_valid <= 1'b0;
      end else if (r_state == ST_EXEC) begin
         r_resp_data  <= bus.lu_y;
         r_resp_valid <= 1'b1;
      end else if (r_state == ST_RESP && bus.resp_ready) begin
         r_resp_valid <= 1'b0;
      end
   end

   // accept strobe only in idle, and never while reset is asserted
   assign bus.req_ready  = (rst_n && r_state == ST_IDLE) ? w_gnt : '0;
   assign bus.lu_a       = r_lu_a;
   assign bus.lu_b       = r_lu_b;
   assign bus.lu_ctrl    = r_lu_ctrl;
   assign bus.resp_valid = r_resp_valid;
   assign bus.resp_data  = r_resp_data;
   assign bus.resp_id    = r_resp_id;
   assign bus.busy       = (r_state != ST_IDLE);

endmodule
